// File: rtl/lap_timer_pkg.sv
// Types and constants shared by the lap timer core and its lap buffer.
package lap_timer_pkg;

  localparam int unsigned FIELD_W = 8;
  localparam logic [FIELD_W-1:0] SEXA_MAX  = FIELD_W'(59);
  localparam logic [FIELD_W-1:0] CENTI_MAX = FIELD_W'(99);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StStopped = 2'd2,
    StExpired = 2'd3
  } state_e;

  typedef struct packed {
    logic [FIELD_W-1:0] hours;
    logic [FIELD_W-1:0] minutes;
    logic [FIELD_W-1:0] seconds;
    logic [FIELD_W-1:0] centisec;
  } time_t;

  localparam int unsigned TIME_W = $bits(time_t);

endpackage

// File: rtl/lap_buffer.sv
// Circular lap snapshot store: append-only until flushed, entries read by age (0 = oldest).
module lap_buffer
  import lap_timer_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = TIME_W,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic [IdxW-1:0]  rd_idx_i,
  output logic [Width-1:0] rd_data_o,
  output logic [IdxW:0]    count_o,
  output logic             full_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [IdxW-1:0]  wr_ptr_q, wr_ptr_d, rd_addr;
  logic [IdxW:0]    count_q, count_d;
  logic             push;

  always_comb begin
    full_o   = (count_q == (IdxW + 1)'(Depth));
    count_o  = count_q;
    push     = wr_en_i & ~full_o & ~flush_i;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end
    // Oldest entry sits count slots behind the write pointer (modulo Depth).
    rd_addr   = wr_ptr_q - count_q[IdxW-1:0] + rd_idx_i;
    rd_data_o = mem_q[rd_addr];
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/lap_timer_core.sv
// hh:mm:ss:xx count-up/countdown timer with expiry alarm, lap capture and lap recall.
module lap_timer_core
  import lap_timer_pkg::*;
#(
  parameter int unsigned HOUR_MAX      = 99,
  parameter int unsigned LAP_DEPTH     = 8,
  parameter int unsigned CD_PRESET_MIN = 1,
  localparam int unsigned IdxW = $clog2(LAP_DEPTH)
) (
  input  logic               clk_100Hz,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               lap,
  input  logic               clear,
  input  logic               recall_next,
  input  logic               min_inc,
  input  logic               hour_inc,
  input  logic               countdown_mode,
  output logic [FIELD_W-1:0] hours,
  output logic [FIELD_W-1:0] minutes,
  output logic [FIELD_W-1:0] seconds,
  output logic [FIELD_W-1:0] centisec,
  output logic [IdxW:0]      lap_count,
  output logic               lap_full,
  output logic               recall_active,
  output logic [IdxW-1:0]    recall_idx,
  output logic               alarm,
  output logic [1:0]         state_o
);

  localparam logic [FIELD_W-1:0] HourMax = FIELD_W'(HOUR_MAX);
  localparam time_t Preset = '{hours: '0, minutes: FIELD_W'(CD_PRESET_MIN),
                               seconds: '0, centisec: '0};

  function automatic time_t time_inc(time_t t);
    time_t r;
    r = t;
    if (t.centisec != CENTI_MAX) r.centisec = t.centisec + 1'b1;
    else begin
      r.centisec = '0;
      if (t.seconds != SEXA_MAX) r.seconds = t.seconds + 1'b1;
      else begin
        r.seconds = '0;
        if (t.minutes != SEXA_MAX) r.minutes = t.minutes + 1'b1;
        else begin
          r.minutes = '0;
          r.hours   = (t.hours >= HourMax) ? '0 : t.hours + 1'b1;
        end
      end
    end
    return r;
  endfunction

  // Borrow chain; saturates at all-zero.
  function automatic time_t time_dec(time_t t);
    time_t r;
    r = t;
    if (t != '0) begin
      if (t.centisec != '0) r.centisec = t.centisec - 1'b1;
      else begin
        r.centisec = CENTI_MAX;
        if (t.seconds != '0) r.seconds = t.seconds - 1'b1;
        else begin
          r.seconds = SEXA_MAX;
          if (t.minutes != '0) r.minutes = t.minutes - 1'b1;
          else begin
            r.minutes = SEXA_MAX;
            r.hours   = t.hours - 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  time_t           time_q, time_d, tick_val, lap_rd, disp;
  logic            mode_q, alarm_q, alarm_d, rec_act_q, rec_act_d;
  logic [IdxW-1:0] rec_idx_q, rec_idx_d;
  logic            mode_rise, mode_edge, clear_ok, stop_ok, start_ok, adj_ok, lap_ok;
  logic            recall_ok, tick, expire, rec_last;

  always_comb begin
    mode_rise = countdown_mode & ~mode_q;
    mode_edge = countdown_mode ^ mode_q;
    clear_ok  = clear & (state_q != StRunning) & ~mode_edge;
    stop_ok   = stop & (state_q == StRunning) & ~mode_edge;
    start_ok  = start & ((state_q == StIdle) | (state_q == StStopped)) & ~mode_edge & ~clear_ok &
                ~(countdown_mode & (time_q == '0));
    adj_ok    = countdown_mode & (min_inc | hour_inc) & (state_q != StRunning) & ~mode_edge &
                ~clear_ok & ~start_ok;
    lap_ok    = lap & (state_q == StRunning) & ~mode_edge;
    recall_ok = recall_next & ((state_q == StIdle) | (state_q == StStopped)) &
                (lap_count != '0) & ~mode_edge & ~clear_ok & ~start_ok;
    tick      = (state_q == StRunning) & ~stop_ok & ~mode_edge;
    tick_val  = countdown_mode ? time_dec(time_q) : time_inc(time_q);
    expire    = tick & countdown_mode & (tick_val == '0);
    rec_last  = ({1'b0, rec_idx_q} == lap_count - 1'b1);
  end

  always_ff @(posedge clk_100Hz) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mode_edge || clear_ok) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (start_ok) state_d = StRunning;
        StRunning: begin
          if (stop_ok)     state_d = StStopped;
          else if (expire) state_d = StExpired;
        end
        StStopped: if (start_ok) state_d = StRunning;
        StExpired: if (adj_ok) state_d = StStopped;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    state_o  = state_q;
    disp     = rec_act_q ? lap_rd : time_q;
    hours    = disp.hours;
    minutes  = disp.minutes;
    seconds  = disp.seconds;
    centisec = disp.centisec;
    alarm         = alarm_q;
    recall_active = rec_act_q;
    recall_idx    = rec_idx_q;
  end

  always_comb begin
    time_d    = time_q;
    alarm_d   = alarm_q;
    rec_act_d = rec_act_q;
    rec_idx_d = rec_idx_q;
    if (mode_edge || clear_ok) begin
      if (mode_edge) time_d = mode_rise ? Preset : '0;
      else           time_d = countdown_mode ? Preset : '0;
      alarm_d   = 1'b0;
      rec_act_d = 1'b0;
      rec_idx_d = '0;
    end else begin
      if (tick) time_d = tick_val;
      if (expire) alarm_d = 1'b1;
      if (start_ok) begin
        alarm_d   = 1'b0;
        rec_act_d = 1'b0;
        rec_idx_d = '0;
      end
      if (adj_ok) begin
        if (min_inc)  time_d.minutes = (time_q.minutes >= SEXA_MAX) ? '0 : time_q.minutes + 1'b1;
        if (hour_inc) time_d.hours   = (time_q.hours >= HourMax) ? '0 : time_q.hours + 1'b1;
        alarm_d = 1'b0;
      end
      if (recall_ok) begin
        if (!rec_act_q) begin
          rec_act_d = 1'b1;
          rec_idx_d = '0;
        end else if (rec_last) begin
          rec_act_d = 1'b0;
          rec_idx_d = '0;
        end else begin
          rec_idx_d = rec_idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_100Hz) begin
    // Tracking the level through reset means no spurious edge once reset drops.
    mode_q <= countdown_mode;
    if (rst) begin
      time_q    <= '0;
      alarm_q   <= 1'b0;
      rec_act_q <= 1'b0;
      rec_idx_q <= '0;
    end else begin
      time_q    <= time_d;
      alarm_q   <= alarm_d;
      rec_act_q <= rec_act_d;
      rec_idx_q <= rec_idx_d;
    end
  end

  lap_buffer #(
    .Depth(LAP_DEPTH),
    .Width(TIME_W)
  ) u_lap_buffer (
    .clk_i    (clk_100Hz),
    .rst_i    (rst),
    .flush_i  (clear_ok),
    .wr_en_i  (lap_ok),
    .wr_data_i(time_q),
    .rd_idx_i (rec_idx_q),
    .rd_data_o(lap_rd),
    .count_o  (lap_count),
    .full_o   (lap_full)
  );

endmodule

// File: tb/tb_lap_timer_core.sv
// Directed and random stimulus for lap_timer_core, checked against an integer-centisecond model.
module tb_lap_timer_core;

  localparam int HMAX   = 2;
  localparam int DEPTH  = 4;
  localparam int PRESET = 1;
  localparam int IDXW   = $clog2(DEPTH);
  localparam int HOUR_CS = 360000;
  localparam int DAY    = (HMAX + 1) * HOUR_CS;
  localparam int S_IDLE = 0, S_RUN = 1, S_STOP = 2, S_EXP = 3;

  logic clk_100Hz = 1'b0;
  logic rst = 1'b0, start = 1'b0, stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic recall_next = 1'b0, min_inc = 1'b0, hour_inc = 1'b0, countdown_mode = 1'b0;
  logic [7:0] hours, minutes, seconds, centisec;
  logic [IDXW:0] lap_count;
  logic [IDXW-1:0] recall_idx;
  logic lap_full, recall_active, alarm;
  logic [1:0] state_o;

  lap_timer_core #(
    .HOUR_MAX(HMAX),
    .LAP_DEPTH(DEPTH),
    .CD_PRESET_MIN(PRESET)
  ) dut (
    .clk_100Hz(clk_100Hz), .rst(rst), .start(start), .stop(stop), .lap(lap), .clear(clear),
    .recall_next(recall_next), .min_inc(min_inc), .hour_inc(hour_inc),
    .countdown_mode(countdown_mode), .hours(hours), .minutes(minutes), .seconds(seconds),
    .centisec(centisec), .lap_count(lap_count), .lap_full(lap_full),
    .recall_active(recall_active), .recall_idx(recall_idx), .alarm(alarm), .state_o(state_o)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  int errors = 0;
  int checks = 0;

  // Reference model: time as total centiseconds, laps as a queue.
  int m_state = S_IDLE, m_t = 0, m_ridx = 0;
  bit m_ract = 1'b0, m_alarm = 1'b0, m_mode = 1'b0;
  int m_laps[$];

  function automatic logic [31:0] fields(int t);
    return {8'(t / HOUR_CS), 8'((t / 6000) % 60), 8'((t / 100) % 60), 8'(t % 100)};
  endfunction

  function automatic logic [31:0] hms(int h, int m, int s, int c);
    return {8'(h), 8'(m), 8'(s), 8'(c)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step();
    bit cd = countdown_mode;
    bit rise = cd && !m_mode;
    bit fall = !cd && m_mode;
    int st0 = m_state;
    m_mode = cd;
    if (rst) begin
      m_state = S_IDLE; m_t = 0; m_laps.delete(); m_ract = 0; m_ridx = 0; m_alarm = 0;
      return;
    end
    if (rise || fall) begin
      m_state = S_IDLE; m_t = rise ? PRESET * 6000 : 0; m_ract = 0; m_ridx = 0; m_alarm = 0;
      return;
    end
    if (clear && st0 != S_RUN) begin
      m_state = S_IDLE; m_t = cd ? PRESET * 6000 : 0; m_laps.delete();
      m_ract = 0; m_ridx = 0; m_alarm = 0;
      return;
    end
    if (st0 == S_RUN) begin
      if (lap && m_laps.size() < DEPTH) m_laps.push_back(m_t);
      if (stop) m_state = S_STOP;
      else if (cd) begin
        if (m_t > 0) m_t--;
        if (m_t == 0) begin m_state = S_EXP; m_alarm = 1; end
      end else m_t = (m_t + 1) % DAY;
      return;
    end
    if (start && st0 != S_EXP && !(cd && m_t == 0)) begin
      m_state = S_RUN; m_ract = 0; m_ridx = 0; m_alarm = 0;
      return;
    end
    if (cd && (min_inc || hour_inc)) begin
      int h = m_t / HOUR_CS;
      int mi = (m_t / 6000) % 60;
      int rest = m_t % 6000;
      if (min_inc) mi = (mi == 59) ? 0 : mi + 1;
      if (hour_inc) h = (h == HMAX) ? 0 : h + 1;
      m_t = h * HOUR_CS + mi * 6000 + rest;
      if (st0 == S_EXP) m_state = S_STOP;
      m_alarm = 0;
    end
    if (recall_next && st0 != S_EXP && m_laps.size() > 0) begin
      if (!m_ract) begin m_ract = 1; m_ridx = 0; end
      else if (m_ridx == m_laps.size() - 1) begin m_ract = 0; m_ridx = 0; end
      else m_ridx++;
    end
  endfunction

  task automatic check_all();
    chk("state", 32'(state_o), 32'(m_state));
    chk("time", {hours, minutes, seconds, centisec}, fields(m_ract ? m_laps[m_ridx] : m_t));
    chk("lap_count", 32'(lap_count), 32'(m_laps.size()));
    chk("lap_full", 32'(lap_full), 32'(m_laps.size() == DEPTH));
    chk("recall", 32'({recall_active, recall_idx}), 32'({m_ract, IDXW'(m_ridx)}));
    chk("alarm", 32'(alarm), 32'(m_alarm));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_100Hz);
    #1;
    {rst, start, stop, lap, clear, recall_next, min_inc, hour_inc} = '0;
    check_all();
  endtask

  initial begin
    // Reset
    rst = 1'b1; cycle();
    chk("rst_state", 32'(state_o), S_IDLE);
    chk("rst_time", {hours, minutes, seconds, centisec}, 32'd0);
    chk("rst_laps", 32'({lap_count, lap_full, recall_active, alarm}), 32'd0);

    // Count up one minute, then hold while stopped
    start = 1'b1; cycle();
    repeat (6000) cycle();
    stop = 1'b1; cycle();
    chk("cu_1min", {hours, minutes, seconds, centisec}, hms(0, 1, 0, 0));
    chk("cu_stopped", 32'(state_o), S_STOP);
    repeat (100) cycle();
    chk("cu_hold", {hours, minutes, seconds, centisec}, hms(0, 1, 0, 0));

    // Countdown from preset to expiry
    clear = 1'b1; cycle();
    countdown_mode = 1'b1; cycle();
    chk("cd_preset", {hours, minutes, seconds, centisec}, hms(0, PRESET, 0, 0));
    start = 1'b1; cycle();
    repeat (6000) cycle();
    chk("cd_zero", {hours, minutes, seconds, centisec}, 32'd0);
    chk("cd_expired", 32'(state_o), S_EXP);
    chk("cd_alarm", 32'(alarm), 32'd1);
    start = 1'b1; cycle();
    chk("cd_start_zero_ignored", 32'(state_o), S_EXP);
    hour_inc = 1'b1; cycle();
    chk("adj_hours", 32'(hours), 32'd1);
    chk("adj_alarm_off", 32'(alarm), 32'd0);
    chk("adj_to_stopped", 32'(state_o), S_STOP);

    // Borrow across the hour, then adjust wraps with no carry
    start = 1'b1; cycle();
    cycle();
    chk("cd_borrow", {hours, minutes, seconds, centisec}, hms(0, 59, 59, 99));
    stop = 1'b1; cycle();
    repeat (3) begin hour_inc = 1'b1; cycle(); end
    min_inc = 1'b1; cycle();
    chk("adj_wrap", {hours, minutes, seconds, centisec}, hms(0, 0, 59, 99));

    // Lap buffer fill past capacity
    countdown_mode = 1'b0; cycle();
    chk("mode_fall", 32'({hours, minutes, seconds, centisec}), 32'd0);
    start = 1'b1; cycle();
    for (int i = 0; i < 70; i++) begin
      lap = (m_t % 10 == 0) && (m_t > 0) && (m_t <= 60);
      cycle();
    end
    chk("lap_count4", 32'(lap_count), 32'd4);
    chk("lap_full", 32'(lap_full), 32'd1);
    stop = 1'b1; cycle();
    for (int k = 0; k < 5; k++) begin
      recall_next = 1'b1; cycle();
      if (k < 4) chk("recall_val", {hours, minutes, seconds, centisec}, hms(0, 0, 0, 10 * (k + 1)));
      chk("recall_active", 32'(recall_active), 32'(k < 4));
    end

    // Simultaneous events
    clear = 1'b1; start = 1'b1; cycle();
    chk("clr_start_state", 32'(state_o), S_IDLE);
    chk("clr_start_time", {hours, minutes, seconds, centisec}, 32'd0);
    start = 1'b1; cycle();
    repeat (5) cycle();
    stop = 1'b1; lap = 1'b1; cycle();
    chk("stop_lap_state", 32'(state_o), S_STOP);
    chk("stop_lap_count", 32'(lap_count), 32'd1);
    recall_next = 1'b1; cycle();
    chk("stop_lap_val", {hours, minutes, seconds, centisec}, hms(0, 0, 0, 5));

    // Reset mid-run with three laps stored
    clear = 1'b1; cycle();
    start = 1'b1; cycle();
    for (int i = 0; i < 30; i++) begin
      lap = (i % 10 == 5);
      cycle();
    end
    chk("pre_rst_laps", 32'(lap_count), 32'd3);
    rst = 1'b1; lap = 1'b1; cycle();
    chk("mid_rst_state", 32'(state_o), S_IDLE);
    chk("mid_rst_time", {hours, minutes, seconds, centisec}, 32'd0);
    chk("mid_rst_misc", 32'({lap_count, lap_full, recall_active, recall_idx, alarm}), 32'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      start       = ($urandom_range(0, 15) == 0);
      stop        = ($urandom_range(0, 31) == 0);
      lap         = ($urandom_range(0, 7) == 0);
      clear       = ($urandom_range(0, 63) == 0);
      recall_next = ($urandom_range(0, 5) == 0);
      min_inc     = ($urandom_range(0, 15) == 0);
      hour_inc    = ($urandom_range(0, 31) == 0);
      rst         = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 299) == 0) countdown_mode = ~countdown_mode;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
